conv3x3_stream: RTL and testbench

- Parametrised streaming 3x3 neighbourhood filter for the camera pixel path.
- Successor to the fixed greyscale convolution stage; sits between greyscale conversion and the SDRAM write FIFOs.
- Generalised over pixel width and line length; adds a runtime kernel mode (passthrough, Gaussian, Sobel, Laplacian) that is latched per frame, plus defined border handling.
- Two line buffers plus a 3x3 window register feed a two-stage arithmetic pipeline.

---
 rtl/conv3x3_stream.sv | 173 +++++++++++++++++
 tb/tb_conv3x3_stream.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_stream
// Purpose  : Streaming 3x3 neighbourhood filter (passthrough, Gaussian,
//            Sobel magnitude, Laplacian magnitude) with two line buffers,
//            per-frame mode latch, zeroed borders and sync-error detection.
// Revision : 1.0 - initial release
// ============================================================================
module conv3x3_stream #(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic              iSOF,
  input  logic [1:0]        iMODE,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic [1:0]        oMODE,
  output logic              oSYNC_ERR
);

  localparam int c_COL_W = $clog2(IMG_W);
  localparam int c_ROW_W = $clog2(IMG_H);
  localparam int c_SW    = DATA_W + 5;
  localparam logic [c_COL_W-1:0]     c_COL_LAST = c_COL_W'(IMG_W - 1);
  localparam logic [c_ROW_W-1:0]     c_ROW_LAST = c_ROW_W'(IMG_H - 1);
  localparam logic signed [c_SW-1:0] c_ROUND    = c_SW'(8);
  localparam logic signed [c_SW-1:0] c_MAX      = $signed({5'b0, {DATA_W{1'b1}}});

  logic [c_COL_W-1:0] r_col;
  logic [c_ROW_W-1:0] r_row;
  logic [1:0]         r_mode;
  logic               r_sync_err;

  // Position of the current beat; a qualified SOF forces it to (0,0).
  logic               w_sof;
  logic [c_COL_W-1:0] w_x;
  logic [c_ROW_W-1:0] w_y;
  logic               w_border;
  assign w_sof    = iSOF & iDVAL;
  assign w_x      = w_sof ? '0 : r_col;
  assign w_y      = w_sof ? '0 : r_row;
  assign w_border = (w_x[c_COL_W-1:1] == '0) || (w_y[c_ROW_W-1:1] == '0);

  // Raster counters, per-frame mode latch and sticky sync error.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_col      <= '0;
      r_row      <= '0;
      r_mode     <= 2'd0;
      r_sync_err <= 1'b0;
    end else if (iDVAL) begin
      if (w_x == c_COL_LAST) begin
        r_col <= '0;
        r_row <= (w_y == c_ROW_LAST) ? '0 : w_y + 1'b1;
      end else begin
        r_col <= w_x + 1'b1;
        r_row <= w_y;
      end
      if (w_sof) begin
        r_mode <= iMODE;
        // Counters sit at (0,0) only right after the last pixel of a frame.
        if ((r_col != '0) || (r_row != '0))
          r_sync_err <= 1'b1;
      end
    end
  end

  assign oMODE     = r_mode;
  assign oSYNC_ERR = r_sync_err;

  // Line buffers: read-before-write, rows y-2 (lb0) and y-1 (lb1).
  logic [DATA_W-1:0] r_lb0 [IMG_W];
  logic [DATA_W-1:0] r_lb1 [IMG_W];
  logic [DATA_W-1:0] w_lb0_rd;
  logic [DATA_W-1:0] w_lb1_rd;
  assign w_lb0_rd = r_lb0[w_x];
  assign w_lb1_rd = r_lb1[w_x];

  // Line-buffer write: lb1 ages into lb0, the new pixel lands in lb1.
  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      r_lb0[w_x] <= w_lb1_rd;
      r_lb1[w_x] <= iDATA;
    end
  end

  // Stage 1: shift the window left and register the per-beat tag.
  logic [DATA_W-1:0] r_win [0:2][0:2];
  logic              r_v1;
  logic              r_border1;
  logic [1:0]        r_mode1;
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          r_win[r][c] <= '0;
      r_v1      <= 1'b0;
      r_border1 <= 1'b0;
      r_mode1   <= 2'd0;
    end else begin
      r_v1 <= iDVAL;
      if (iDVAL) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= w_lb0_rd;
        r_win[1][2] <= w_lb1_rd;
        r_win[2][2] <= iDATA;
        r_border1   <= w_border;
        r_mode1     <= w_sof ? iMODE : r_mode;
      end
    end
  end

  // Window taps widened to signed so differences never wrap.
  logic signed [c_SW-1:0] w_p [0:2][0:2];
  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w_p[r][c] = $signed({5'b0, r_win[r][c]});
  end

  logic signed [c_SW-1:0] w_gsum, w_gauss, w_gx, w_gy, w_lap;
  logic signed [c_SW-1:0] w_gx_abs, w_gy_abs, w_lap_abs;
  assign w_gsum = w_p[0][0] + (w_p[0][1] <<< 1) + w_p[0][2]
                + (w_p[1][0] <<< 1) + (w_p[1][1] <<< 2) + (w_p[1][2] <<< 1)
                + w_p[2][0] + (w_p[2][1] <<< 1) + w_p[2][2];
  assign w_gauss = (w_gsum + c_ROUND) >>> 4;
  assign w_gx = (w_p[0][2] + (w_p[1][2] <<< 1) + w_p[2][2])
              - (w_p[0][0] + (w_p[1][0] <<< 1) + w_p[2][0]);
  assign w_gy = (w_p[2][0] + (w_p[2][1] <<< 1) + w_p[2][2])
              - (w_p[0][0] + (w_p[0][1] <<< 1) + w_p[0][2]);
  assign w_lap = (w_p[1][1] <<< 3)
               - (w_p[0][0] + w_p[0][1] + w_p[0][2] + w_p[1][0]
                + w_p[1][2] + w_p[2][0] + w_p[2][1] + w_p[2][2]);
  assign w_gx_abs  = w_gx[c_SW-1]  ? -w_gx  : w_gx;
  assign w_gy_abs  = w_gy[c_SW-1]  ? -w_gy  : w_gy;
  assign w_lap_abs = w_lap[c_SW-1] ? -w_lap : w_lap;

  // Kernel select and saturation to the pixel range.
  logic signed [c_SW-1:0] w_res;
  logic [DATA_W-1:0]      w_sat;
  always_comb begin
    w_res = w_p[1][1];
    case (r_mode1)
      2'd1:    w_res = w_gauss;
      2'd2:    w_res = w_gx_abs + w_gy_abs;
      2'd3:    w_res = w_lap_abs;
      default: w_res = w_p[1][1];
    endcase
    w_sat = (w_res > c_MAX) ? {DATA_W{1'b1}} : w_res[DATA_W-1:0];
  end

  // Stage 2: register the result, zeroing incomplete border windows.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oDVAL <= 1'b0;
      oDATA <= '0;
    end else begin
      oDVAL <= r_v1;
      if (r_v1)
        oDATA <= r_border1 ? '0 : w_sat;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv3x3_stream
// Purpose  : Directed, table-driven bench for conv3x3_stream on an 8x6 frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv3x3_stream;

  localparam int DW = 12;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] iDATA;
  logic          iDVAL;
  logic          iSOF;
  logic [1:0]    iMODE;
  logic [DW-1:0] oDATA;
  logic          oDVAL;
  logic [1:0]    oMODE;
  logic          oSYNC_ERR;

  conv3x3_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .iCLK      (clk),
    .iRST      (rst),
    .iDATA     (iDATA),
    .iDVAL     (iDVAL),
    .iSOF      (iSOF),
    .iMODE     (iMODE),
    .oDATA     (oDATA),
    .oDVAL     (oDVAL),
    .oMODE     (oMODE),
    .oSYNC_ERR (oSYNC_ERR)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int in_cyc[$];
  logic [DW-1:0] out_q[$];
  logic [DW-1:0] img [0:H-1][0:W-1];
  logic [DW-1:0] cap [0:6][0:N-1];

  typedef struct {
    string nm;
    int    fid;
    int    x;
    int    y;
    int    exp;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input int fid, input int x, input int y, input int exp);
    vec_t v;
    v.nm = nm; v.fid = fid; v.x = x; v.y = y; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Every output beat must trail its input beat by exactly two cycles.
  always @(negedge clk) begin
    if (oDVAL === 1'b1) begin
      out_q.push_back(oDATA);
      if (in_cyc.size() == 0) chk("unexpected_oDVAL", 1, 0);
      else                    chk("latency", cyc - in_cyc.pop_front(), 2);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic sof);
    iDATA = d; iDVAL = 1'b1; iSOF = sof;
    in_cyc.push_back(cyc);
    @(posedge clk); #1;
    iDVAL = 1'b0; iSOF = 1'b0;
  endtask

  task automatic run_frame(input int fid, input logic sof, input int gaps,
                           input int switch_at, input logic [1:0] m2);
    out_q.delete();
    for (int i = 0; i < N; i++) begin
      if (i == switch_at) iMODE = m2;
      if (gaps != 0 && $urandom_range(1) == 1) idle($urandom_range(1, 2));
      beat(img[i / W][i % W], sof && (i == 0));
    end
    idle(4);
    chk("frame_out_count", out_q.size(), N);
    for (int i = 0; i < N; i++)
      cap[fid][i] = (i < out_q.size()) ? out_q[i] : 12'hABC;
  endtask

  task automatic fill_flat(input logic [DW-1:0] v);
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back(mk("gauss_step_edge_l", 1, 4, 2, 1024));
    vecs.push_back(mk("gauss_step_edge_r", 1, 5, 3, 3071));
    vecs.push_back(mk("gauss_step_high",   1, 6, 4, 4095));
    vecs.push_back(mk("gauss_step_low",    1, 3, 3, 0));
    vecs.push_back(mk("gauss_step_corner", 1, 7, 5, 4095));
    vecs.push_back(mk("gauss_step_border", 1, 4, 1, 0));
    vecs.push_back(mk("sobel_low_l",       2, 3, 2, 0));
    vecs.push_back(mk("sobel_edge_a",      2, 4, 2, 4095));
    vecs.push_back(mk("sobel_edge_b",      2, 5, 3, 4095));
    vecs.push_back(mk("sobel_high_flat",   2, 6, 4, 0));
    vecs.push_back(mk("sobel_high_corner", 2, 7, 5, 0));
    vecs.push_back(mk("sobel_left_border", 2, 1, 3, 0));
    vecs.push_back(mk("sobel_top_border",  2, 4, 1, 0));
    vecs.push_back(mk("lap_centre",        3, 5, 4, 80));
    vecs.push_back(mk("lap_nb_ul",         3, 4, 3, 10));
    vecs.push_back(mk("lap_nb_u",          3, 5, 3, 10));
    vecs.push_back(mk("lap_nb_ur",         3, 6, 3, 10));
    vecs.push_back(mk("lap_nb_l",          3, 4, 4, 10));
    vecs.push_back(mk("lap_nb_r",          3, 6, 4, 10));
    vecs.push_back(mk("lap_nb_dl",         3, 4, 5, 10));
    vecs.push_back(mk("lap_nb_d",          3, 5, 5, 10));
    vecs.push_back(mk("lap_nb_dr",         3, 6, 5, 10));
    vecs.push_back(mk("lap_far_r",         3, 7, 4, 0));
    vecs.push_back(mk("lap_far_l",         3, 3, 3, 0));
    vecs.push_back(mk("resync_first_int",  5, 2, 2, 50));
    vecs.push_back(mk("resync_left_bord",  5, 1, 2, 0));
    vecs.push_back(mk("resync_top_bord",   5, 2, 1, 0));
    vecs.push_back(mk("resync_last",       5, 7, 5, 50));
    vecs.push_back(mk("postrst_first_int", 6, 2, 2, 70));
    vecs.push_back(mk("postrst_left_bord", 6, 1, 2, 0));
    vecs.push_back(mk("postrst_top_bord",  6, 2, 1, 0));
    vecs.push_back(mk("postrst_last",      6, 7, 5, 70));

    rst = 1'b1; iDATA = '0; iDVAL = 1'b0; iSOF = 1'b0; iMODE = 2'd0;
    idle(3);
    chk("reset_oDVAL", oDVAL, 0);
    chk("reset_oDATA", oDATA, 0);
    chk("reset_oMODE", oMODE, 0);
    chk("reset_oSYNC_ERR", oSYNC_ERR, 0);
    rst = 1'b0;
    idle(2);

    // Flat 100, Gaussian: border beats 0, interior 100.
    fill_flat(12'd100);
    iMODE = 2'd1;
    run_frame(0, 1'b1, 0, -1, 2'd0);
    for (int i = 0; i < N; i++)
      chk("flat_gauss", cap[0][i], ((i % W) < 2 || (i / W) < 2) ? 0 : 100);
    chk("flat_gauss_oMODE", oMODE, 1);

    // Vertical step, Gaussian latched; iMODE moves to Sobel mid-frame.
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = (x < 4) ? 12'd0 : 12'd4095;
    iMODE = 2'd1;
    run_frame(1, 1'b1, 0, 1, 2'd2);
    chk("mode_held_mid_frame", oMODE, 1);

    // Same step, Sobel now latched at SOF.
    run_frame(2, 1'b1, 0, -1, 2'd0);
    chk("sobel_oMODE", oMODE, 2);

    // Impulse 10 at (4,3), Laplacian.
    fill_flat(12'd0);
    img[3][4] = 12'd10;
    iMODE = 2'd3;
    run_frame(3, 1'b1, 0, -1, 2'd0);

    // Random pixels with gaps, passthrough: output is input one line + one pixel earlier.
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = DW'($urandom_range(4095));
    iMODE = 2'd0;
    run_frame(4, 1'b1, 1, -1, 2'd0);
    for (int i = 0; i < N; i++) begin
      int x, y;
      x = i % W; y = i / W;
      chk("pass_gaps", cap[4][i], (x < 2 || y < 2) ? 0 : img[y-1][x-1]);
    end
    chk("sync_err_clean", oSYNC_ERR, 0);

    // Partial frame, then SOF where (3,2) would be.
    fill_flat(12'd50);
    for (int i = 0; i < 19; i++) beat(img[i / W][i % W], i == 0);
    idle(4);
    chk("sync_err_before_sof", oSYNC_ERR, 0);
    run_frame(5, 1'b1, 0, -1, 2'd0);
    chk("sync_err_sticky", oSYNC_ERR, 1);

    // Reset while beats are in flight.
    fill_flat(12'd100);
    iMODE = 2'd1;
    for (int i = 0; i < 20; i++) beat(img[i / W][i % W], i == 0);
    chk("pre_reset_dval", oDVAL, 1);
    #2;
    rst = 1'b1;
    in_cyc.delete();
    out_q.delete();
    #1;
    chk("mid_reset_oDVAL", oDVAL, 0);
    chk("mid_reset_oDATA", oDATA, 0);
    chk("mid_reset_oMODE", oMODE, 0);
    chk("mid_reset_oSYNC_ERR", oSYNC_ERR, 0);
    idle(2);
    #2;
    rst = 1'b0;
    idle(4);
    chk("flushed_no_output", out_q.size(), 0);

    // No SOF after reset: counting starts at (0,0), mode stays passthrough.
    fill_flat(12'd70);
    iMODE = 2'd3;
    run_frame(6, 1'b0, 0, -1, 2'd0);
    chk("postrst_oMODE", oMODE, 0);

    foreach (vecs[k])
      chk(vecs[k].nm, cap[vecs[k].fid][vecs[k].y * W + vecs[k].x], vecs[k].exp);

    chk("all_beats_emitted", in_cyc.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
